// File: rtl/mult_rr_arbiter.sv
// rtl/mult_rr_arbiter.sv - round-robin arbiter sharing one signed 4x4 multiplier
//
// MultS4Bits: combinational signed 4x4 -> 8 multiplier.
//   x, y  : signed 4-bit operands
//   p     : signed 8-bit exact product
//
// mult_rr_arbiter: NREQ requesters share one MultS4Bits via round-robin grant.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : per-requester operand handshake (ready is one-hot grant)
//   req_x, req_y      : packed signed 4-bit operands, requester i at [4i+3:4i]
//   res_valid/ready   : registered result handshake with backpressure
//   res_id, res_prod  : owning requester index and signed product
//   busy              : high whenever the FSM is not IDLE
//   ops_done          : wrapping count of results accepted by the consumer
`timescale 1ns/1ps

module MultS4Bits (
    input  logic signed [3:0] x,
    input  logic signed [3:0] y,
    output logic signed [7:0] p
);
    assign p = x * y;
endmodule

module mult_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [4*NREQ-1:0]    req_x,
    input  logic [4*NREQ-1:0]    req_y,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDW-1:0]       res_id,
    output logic [7:0]           res_prod,
    output logic                 busy,
    output logic [CNTW-1:0]      ops_done
);
    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t            state;
    state_t            state_next;
    logic [IDW-1:0]    last_grant;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    win_id;
    logic [3:0]        win_x;
    logic [3:0]        win_y;
    logic [3:0]        op_x;
    logic [3:0]        op_y;
    logic [IDW-1:0]    op_id;
    logic signed [7:0] prod;

    MultS4Bits u_mult (
        .x (op_x),
        .y (op_y),
        .p (prod)
    );

    // Search starts one past the previous winner and wraps, so the most
    // recently served requester has the lowest priority.
    always_comb begin
        int idx;
        idx    = 0;
        grant  = '0;
        win_id = '0;
        win_x  = '0;
        win_y  = '0;
        if (state == IDLE) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(last_grant) + k) % NREQ;
                if (grant == '0 && req_valid[idx]) begin
                    grant[idx] = 1'b1;
                    win_id     = IDW'(idx);
                    win_x      = req_x[4*idx +: 4];
                    win_y      = req_y[4*idx +: 4];
                end
            end
        end
    end

    // Grant is suppressed while reset is asserted so no transfer is implied
    // in a cycle whose state update is being discarded.
    assign req_ready = rst ? '0 : grant;
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|grant) state_next = CALC;
            CALC:    state_next = HOLD;
            HOLD:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            op_x       <= '0;
            op_y       <= '0;
            op_id      <= '0;
            res_valid  <= 1'b0;
            res_id     <= '0;
            res_prod   <= '0;
            ops_done   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        op_x       <= win_x;
                        op_y       <= win_y;
                        op_id      <= win_id;
                        last_grant <= win_id;
                    end
                end
                CALC: begin
                    res_prod  <= prod;
                    res_id    <= op_id;
                    res_valid <= 1'b1;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ops_done  <= ops_done + CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_rr_arbiter.sv
// tb/tb_mult_rr_arbiter.sv - directed self-checking bench for mult_rr_arbiter
`timescale 1ns/1ps

module tb_mult_rr_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_x;
    logic [15:0] req_y;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [7:0]  res_prod;
    logic        busy;
    logic [3:0]  ops_done;

    int pass_cnt = 0;
    int total    = 0;

    mult_rr_arbiter #(.NREQ(4), .IDW(2), .CNTW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_prod  (res_prod),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from an idle arbiter and waits for its result;
    // the result is accepted at the edge after it is captured.
    task automatic run_one(input int idx, input logic [3:0] xv, input logic [3:0] yv,
                           output logic [1:0] id, output logic [7:0] prod, output bit ok);
        int n;
        req_x = '0;
        req_y = '0;
        req_x[4*idx +: 4] = xv;
        req_y[4*idx +: 4] = yv;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        res_ready = 1'b1;
        step();
        req_valid = '0;
        n = 0;
        while (!res_valid && n < 10) begin
            step();
            n++;
        end
        ok   = res_valid;
        id   = res_id;
        prod = res_prod;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; req_x = '0; req_y = '0; res_ready = 1'b0;
        step();
        step();
        total++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b exp=0000", req_ready); else pass_cnt++;
        total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got=%b exp=0", res_valid); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total++; if (ops_done !== 4'd0) $display("FAIL reset_ops_done got=%0d exp=0", ops_done); else pass_cnt++;
        total++; if ({res_id, res_prod} !== 10'd0) $display("FAIL reset_result got=%h/%h exp=0/00", res_id, res_prod); else pass_cnt++;
        rst = 1'b0; req_valid = '0;
        step();
    endtask

    task automatic test_basic();
        req_x = 16'h0007; req_y = 16'h0007; req_valid = 4'b0001; res_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL basic_grant got=%b exp=0001", req_ready); else pass_cnt++;
        step();
        req_valid = '0;
        total++; if ({res_valid, busy} !== 2'b01) $display("FAIL basic_calc got=%b exp=01", {res_valid, busy}); else pass_cnt++;
        step();
        total++; if (res_valid !== 1'b1) $display("FAIL basic_latency got=%b exp=1", res_valid); else pass_cnt++;
        total++; if (res_id !== 2'd0) $display("FAIL basic_id got=%0d exp=0", res_id); else pass_cnt++;
        total++; if (res_prod !== 8'h31) $display("FAIL basic_prod got=%h exp=31", res_prod); else pass_cnt++;
        step();
        total++; if (ops_done !== 4'd1) $display("FAIL basic_ops_done got=%0d exp=1", ops_done); else pass_cnt++;
        total++; if (res_valid !== 1'b0) $display("FAIL basic_release got=%b exp=0", res_valid); else pass_cnt++;
    endtask

    task automatic test_signed();
        logic [3:0] xs [5] = '{4'h8, 4'h8, 4'hF, 4'h3, 4'h0};
        logic [3:0] ys [5] = '{4'h8, 4'h7, 4'hF, 4'hC, 4'h8};
        logic [7:0] ps [5] = '{8'h40, 8'hC8, 8'h01, 8'hF4, 8'h00};
        logic [1:0] id;
        logic [7:0] prod;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            run_one(2, xs[i], ys[i], id, prod, ok);
            total++; if (!ok) $display("FAIL signed_timeout vec=%0d got=no result exp=result", i); else pass_cnt++;
            total++; if ({id, prod} !== {2'd2, ps[i]}) $display("FAIL signed_prod vec=%0d got=%0d/%h exp=2/%h", i, id, prod, ps[i]); else pass_cnt++;
        end
        total++; if (ops_done !== 4'd6) $display("FAIL signed_ops_done got=%0d exp=6", ops_done); else pass_cnt++;
    endtask

    task automatic test_fairness();
        logic [7:0] ps [4] = '{8'hFD, 8'hFA, 8'hF7, 8'hF4};
        logic [3:0] g1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_x = 16'h4321; req_y = 16'hDDDD; req_valid = 4'b1111; res_ready = 1'b1;
        #1;
        for (int n = 0; n < 8; n++) begin
            g1 = 4'b0001 << (n % 4);
            total++; if (req_ready !== g1) $display("FAIL fair_grant op=%0d got=%b exp=%b", n, req_ready, g1); else pass_cnt++;
            step();
            total++; if (req_ready !== 4'b0000) $display("FAIL fair_calc_ready op=%0d got=%b exp=0000", n, req_ready); else pass_cnt++;
            step();
            total++; if ({res_valid, res_id, res_prod} !== {1'b1, 2'(n % 4), ps[n % 4]})
                $display("FAIL fair_result op=%0d got=%b/%0d/%h exp=1/%0d/%h", n, res_valid, res_id, res_prod, n % 4, ps[n % 4]);
            else pass_cnt++;
            step();
        end
        total++; if (ops_done !== 4'd8) $display("FAIL fair_ops_done got=%0d exp=8", ops_done); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        step();
        step();
        for (int c = 0; c < 10; c++) begin
            total++; if ({res_valid, res_id, res_prod, req_ready, busy, ops_done} !== {1'b1, 2'd0, 8'hFD, 4'b0000, 1'b1, 4'd8})
                $display("FAIL bp_hold cyc=%0d got=%b/%0d/%h/%b/%b/%0d exp=1/0/fd/0000/1/8", c, res_valid, res_id, res_prod, req_ready, busy, ops_done);
            else pass_cnt++;
            step();
        end
        res_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0000) $display("FAIL bp_accept_ready got=%b exp=0000", req_ready); else pass_cnt++;
        step();
        total++; if (ops_done !== 4'd9) $display("FAIL bp_ops_done got=%0d exp=9", ops_done); else pass_cnt++;
        total++; if ({res_valid, req_ready} !== 5'b0_0010) $display("FAIL bp_next_grant got=%b/%b exp=0/0010", res_valid, req_ready); else pass_cnt++;
        step();
        step();
        total++; if ({res_id, res_prod} !== {2'd1, 8'hFA}) $display("FAIL bp_next_result got=%0d/%h exp=1/fa", res_id, res_prod); else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b1001;
        #1;
        total++; if (req_ready !== 4'b1000) $display("FAIL mid_rr_grant got=%b exp=1000", req_ready); else pass_cnt++;
        step();
        rst = 1'b1;
        step();
        total++; if ({res_valid, busy, ops_done, req_ready} !== 10'd0)
            $display("FAIL mid_calc_reset got=%b/%b/%0d/%b exp=0/0/0/0000", res_valid, busy, ops_done, req_ready);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL mid_calc_prio got=%b exp=0001", req_ready); else pass_cnt++;
        res_ready = 1'b0;
        step();
        step();
        total++; if (res_valid !== 1'b1) $display("FAIL mid_hold_reach got=%b exp=1", res_valid); else pass_cnt++;
        rst = 1'b1;
        step();
        total++; if ({res_valid, busy, ops_done, req_ready} !== 10'd0)
            $display("FAIL mid_hold_reset got=%b/%b/%0d/%b exp=0/0/0/0000", res_valid, busy, ops_done, req_ready);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL mid_hold_prio got=%b exp=0001", req_ready); else pass_cnt++;
        req_valid = '0;
        res_ready = 1'b1;
        step();
    endtask

    task automatic test_wrap();
        logic [1:0] id;
        logic [7:0] prod;
        bit ok;
        res_ready = 1'b1; req_valid = '0;
        step();
        step();
        step();
        total++; if (ops_done !== 4'd0) $display("FAIL wrap_idle_ready got=%0d exp=0", ops_done); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            run_one(1, 4'h2, 4'h3, id, prod, ok);
            total++; if (!ok || {id, prod} !== {2'd1, 8'h06}) $display("FAIL wrap_op op=%0d got=%b/%0d/%h exp=1/1/06", i, ok, id, prod); else pass_cnt++;
            if (i == 14) begin
                total++; if (ops_done !== 4'd15) $display("FAIL wrap_max got=%0d exp=15", ops_done); else pass_cnt++;
            end
        end
        total++; if (ops_done !== 4'd0) $display("FAIL wrap_zero got=%0d exp=0", ops_done); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; res_ready = 1'b0;
        test_reset();
        test_basic();
        test_signed();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
